// File: rtl/lab_io_pkg.sv
// Shared definitions for the lab board I/O wrapper.
// Holds the display-mode encoding, the synchroniser depth and the mode-advance helper.
// Optional macro LAB_IO_WRAPPER_DIFF_EN inserts the DIFF mode into the cycle.
package lab_io_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    MODE_SUM   = 3'd0,
    MODE_FLAGS = 3'd1,
    MODE_OPA   = 3'd2,
    MODE_OPB   = 3'd3,
    MODE_DIFF  = 3'd4
  } mode_t;

  // Display mode order: SUM -> FLAGS -> (DIFF) -> OPA -> OPB -> SUM
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_SUM:   n = MODE_FLAGS;
`ifdef LAB_IO_WRAPPER_DIFF_EN
      MODE_FLAGS: n = MODE_DIFF;
      MODE_DIFF:  n = MODE_OPA;
`else
      MODE_FLAGS: n = MODE_OPA;
`endif
      MODE_OPA:   n = MODE_OPB;
      MODE_OPB:   n = MODE_SUM;
      default:    n = MODE_SUM;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: synchronise one raw button, debounce it, emit a one-cycle pulse per press.
// Latency: input driven after edge 0 -> debounced level rises at edge DEBOUNCE+2, press high the following cycle.
// Backpressure: none; free-running, every accepted press produces exactly one pulse.
// Ports: clk, reset (sync, active-high), btn_raw (asynchronous pin), press (1-cycle pulse on 0->1 debounced edge).
module btn_debounce
  import lab_io_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   db_dly_q;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (sync == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
      // Level has disagreed for DEBOUNCE consecutive cycles: accept it.
      db_d  = sync;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  // Rising edge of the debounced level only; release produces nothing.
  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/lab_io_wrapper.sv
// Purpose: board-level wrapper loading W-bit operands by nibble from switches, driving an adder and a 4-LED view.
// Latency: button driven after edge 0 -> operand/mode/pointer update at edge DEBOUNCE+3, led at DEBOUNCE+4.
// Backpressure: none; each debounced press commits its action in a single cycle.
// Ports: clk; reset (sync, active-high); sw[3:0] nibble to load; btn[3:0] raw buttons
//   ([0] load A nibble, [1] load B nibble, [2] next display mode, [3] next nibble pointer);
//   led[3:0] registered display nibble; op_a/op_b[W-1:0] stored operands for observation.
// Optional macro LAB_IO_WRAPPER_DIFF_EN adds a DIFF display mode showing op_a - op_b.
module lab_io_wrapper
  import lab_io_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   sw,
  input  logic [3:0]   btn,
  output logic [3:0]   led,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b
);

  localparam int NIB = W / 4;
  localparam int PW  = (NIB > 1) ? $clog2(NIB) : 1;

  logic [3:0]    press;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [PW-1:0] ptr_q, ptr_d;
  mode_t         mode_q, mode_d;
  logic [3:0]    led_q, led_d;

  logic [W:0]    sum_ext;
  logic [W-1:0]  sum;
  logic          cout, ovf, zero, neg;
  logic [3:0]    sum_nib, a_nib, b_nib;
`ifdef LAB_IO_WRAPPER_DIFF_EN
  logic [W-1:0]  diff;
  logic [3:0]    diff_nib;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn[g]),
      .press   (press[g])
    );
  end

  // Arithmetic on the stored operands.
  always_comb begin
    sum_ext = {1'b0, op_a_q} + {1'b0, op_b_q};
    sum     = sum_ext[W-1:0];
    cout    = sum_ext[W];
    ovf     = (op_a_q[W-1] == op_b_q[W-1]) & (sum[W-1] != op_a_q[W-1]);
    zero    = (sum == '0);
    neg     = sum[W-1];
  end

`ifdef LAB_IO_WRAPPER_DIFF_EN
  assign diff = op_a_q - op_b_q;
`endif

  // Nibble selection by pointer; a decoded loop keeps every select index constant.
  always_comb begin
    sum_nib  = '0;
    a_nib    = '0;
    b_nib    = '0;
`ifdef LAB_IO_WRAPPER_DIFF_EN
    diff_nib = '0;
`endif
    for (int i = 0; i < NIB; i++) begin
      if (ptr_q == PW'(i)) begin
        sum_nib  = sum[4*i +: 4];
        a_nib    = op_a_q[4*i +: 4];
        b_nib    = op_b_q[4*i +: 4];
`ifdef LAB_IO_WRAPPER_DIFF_EN
        diff_nib = diff[4*i +: 4];
`endif
      end
    end
  end

  // Press actions. Loads use the pointer value before any same-cycle increment.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    ptr_d  = ptr_q;
    mode_d = mode_q;
    for (int i = 0; i < NIB; i++) begin
      if (ptr_q == PW'(i)) begin
        if (press[0]) op_a_d[4*i +: 4] = sw;
        if (press[1]) op_b_d[4*i +: 4] = sw;
      end
    end
    if (press[2]) mode_d = next_mode(mode_q);
    if (press[3]) ptr_d = (ptr_q == PW'(NIB - 1)) ? '0 : ptr_q + 1'b1;
  end

  // LED reflects the committed state, so it trails an action by one cycle.
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_SUM:   led_d = sum_nib;
      MODE_FLAGS: led_d = {neg, zero, ovf, cout};
      MODE_OPA:   led_d = a_nib;
      MODE_OPB:   led_d = b_nib;
`ifdef LAB_IO_WRAPPER_DIFF_EN
      MODE_DIFF:  led_d = diff_nib;
`endif
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
      ptr_q  <= '0;
      mode_q <= MODE_SUM;
      led_q  <= '0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      ptr_q  <= ptr_d;
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign led  = led_q;
  assign op_a = op_a_q;
  assign op_b = op_b_q;

endmodule

// File: tb/tb_lab_io_wrapper.sv
// Purpose: self-checking bench for lab_io_wrapper at W=8, DEBOUNCE=4.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after later edges.
// Backpressure: not applicable; expectations queue in a scoreboard and are popped when the DUT responds.
module tb_lab_io_wrapper;

  localparam int W   = 8;
  localparam int DEB = 4;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   sw;
  logic [3:0]   btn;
  logic [3:0]   led;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  always #5 clk = ~clk;

  lab_io_wrapper #(.W(W), .DEBOUNCE(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .btn   (btn),
    .led   (led),
    .op_a  (op_a),
    .op_b  (op_b)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   l_old;
    logic [3:0]   l_new;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [W-1:0] m_a, m_b;
  int           m_ptr;
  int           m_mode;   // 0 SUM, 1 FLAGS, 2 OPA, 3 OPB, 4 DIFF

  function automatic logic [3:0] model_led();
    logic [W:0]   s;
    logic [W-1:0] sm, df;
    logic         ov;
    s  = {1'b0, m_a} + {1'b0, m_b};
    sm = s[W-1:0];
    df = m_a - m_b;
    ov = (m_a[W-1] == m_b[W-1]) && (sm[W-1] != m_a[W-1]);
    case (m_mode)
      0:       return sm[4*m_ptr +: 4];
      1:       return {sm[W-1], (sm == '0), ov, s[W]};
      2:       return m_a[4*m_ptr +: 4];
      3:       return m_b[4*m_ptr +: 4];
      4:       return df[4*m_ptr +: 4];
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_ptr = 0; m_mode = 0;
  endtask

  task automatic model_apply(input logic [3:0] mask, input logic [3:0] swv);
    if (mask[0]) m_a[4*m_ptr +: 4] = swv;
    if (mask[1]) m_b[4*m_ptr +: 4] = swv;
    if (mask[2]) begin
      case (m_mode)
        0: m_mode = 1;
`ifdef LAB_IO_WRAPPER_DIFF_EN
        1: m_mode = 4;
        4: m_mode = 2;
`else
        1: m_mode = 2;
`endif
        2: m_mode = 3;
        default: m_mode = 0;
      endcase
    end
    if (mask[3]) m_ptr = (m_ptr == NIB - 1) ? 0 : m_ptr + 1;
  endtask

  // Drives one clean press held 8 cycles, records the DUT response at the edge
  // the state should update (7 edges after drive) and when the led should follow (8).
  task automatic drive_press(input logic [3:0] mask, input logic [3:0] swv,
                             output logic [W-1:0] a_obs, output logic [W-1:0] b_obs,
                             output logic [3:0] l7, output logic [3:0] l8);
    exp_t e;
    @(posedge clk); #1;
    e.l_old = model_led();
    model_apply(mask, swv);
    e.a = m_a;
    e.b = m_b;
    e.l_new = model_led();
    sb_q.push_back(e);
    sw  = swv;
    btn = mask;
    repeat (7) @(posedge clk);
    #1;
    a_obs = op_a; b_obs = op_b; l7 = led;
    @(posedge clk); #1;
    l8  = led;
    btn = 4'h0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] a, b;
    logic [3:0]   l7, l8;
    exp_t         e;
    reset = 1'b1; btn = 4'h0; sw = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (led !== 4'h0) begin n_err++; $display("FAIL reset_led: got %b want 0000", led); end
    n_vec++; if (op_a !== '0) begin n_err++; $display("FAIL reset_op_a: got %h want 00", op_a); end
    n_vec++; if (op_b !== '0) begin n_err++; $display("FAIL reset_op_b: got %h want 00", op_b); end
    reset = 1'b0;
    model_reset();
    drive_press(4'b0100, 4'h0, a, b, l7, l8);
    e = sb_q.pop_front();
    n_vec++;
    if ({a, b, l7, l8} !== {e.a, e.b, e.l_old, e.l_new}) begin
      n_err++;
      $display("FAIL reset_to_flags: got a=%h b=%h led7=%b led8=%b want a=%h b=%h led7=%b led8=%b",
               a, b, l7, l8, e.a, e.b, e.l_old, e.l_new);
    end
    n_vec++; if (l8 !== 4'b0100) begin n_err++; $display("FAIL flags_zero: got %b want 0100", l8); end
  endtask

  task automatic test_load();
    logic [3:0]   masks [9] = '{4'h4, 4'h4, 4'h4, 4'h1, 4'h8, 4'h1, 4'h8, 4'h2, 4'h8};
    logic [3:0]   sws   [9] = '{4'h0, 4'h0, 4'h0, 4'hC, 4'h0, 4'h3, 4'h0, 4'h5, 4'h0};
    logic [W-1:0] a, b;
    logic [3:0]   l7, l8;
    exp_t         e;
    for (int i = 0; i < 9; i++) begin
      drive_press(masks[i], sws[i], a, b, l7, l8);
      e = sb_q.pop_front();
      n_vec++;
      if ({a, b, l7, l8} !== {e.a, e.b, e.l_old, e.l_new}) begin
        n_err++;
        $display("FAIL load[%0d]: got a=%h b=%h led7=%h led8=%h want a=%h b=%h led7=%h led8=%h",
                 i, a, b, l7, l8, e.a, e.b, e.l_old, e.l_new);
      end
      if (i == 7) begin
        n_vec++; if (l8 !== 4'h1) begin n_err++; $display("FAIL sum_nib0: got %h want 1", l8); end
      end
    end
    n_vec++; if (op_a !== 8'h3C) begin n_err++; $display("FAIL load_op_a: got %h want 3c", op_a); end
    n_vec++; if (op_b !== 8'h05) begin n_err++; $display("FAIL load_op_b: got %h want 05", op_b); end
    n_vec++; if (led !== 4'h4) begin n_err++; $display("FAIL sum_nib1: got %h want 4", led); end
  endtask

  task automatic test_flags();
    logic [3:0]   masks [7] = '{4'h1, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0]   sws   [7] = '{4'h7, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0, 4'hF};
    logic [W-1:0] a, b;
    logic [3:0]   l7, l8;
    exp_t         e;
    for (int i = 0; i < 7; i++) begin
      drive_press(masks[i], sws[i], a, b, l7, l8);
      e = sb_q.pop_front();
      n_vec++;
      if ({a, b, l7, l8} !== {e.a, e.b, e.l_old, e.l_new}) begin
        n_err++;
        $display("FAIL flags[%0d]: got a=%h b=%h led7=%b led8=%b want a=%h b=%h led7=%b led8=%b",
                 i, a, b, l7, l8, e.a, e.b, e.l_old, e.l_new);
      end
      if (i == 4) begin
        n_vec++; if (l8 !== 4'b1010) begin n_err++; $display("FAIL flags_ovf: got %b want 1010", l8); end
      end
      if (i == 6) begin
        n_vec++; if (l8 !== 4'b0101) begin n_err++; $display("FAIL flags_cout: got %b want 0101", l8); end
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    @(posedge clk); #1;
    sw  = 4'h2;
    btn = 4'h0;
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      repeat (2) @(posedge clk);
      #1;
    end
    btn = 4'h0;
    repeat (12) @(posedge clk);
    #1;
    n_vec++; if (op_a !== m_a) begin n_err++; $display("FAIL bounce_toggle: got %h want %h", op_a, m_a); end
    btn = 4'h1;
    repeat (3) @(posedge clk);
    #1;
    btn = 4'h0;
    repeat (12) @(posedge clk);
    #1;
    n_vec++; if (op_a !== m_a) begin n_err++; $display("FAIL bounce_3cyc: got %h want %h", op_a, m_a); end
    model_apply(4'h1, 4'h2);
    e.a = m_a; e.b = m_b; e.l_old = 4'h0; e.l_new = model_led();
    sb_q.push_back(e);
    btn = 4'h1;
    repeat (4) @(posedge clk);
    #1;
    btn = 4'h0;
    repeat (16) @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_vec++;
    if ({op_a, op_b, led} !== {e.a, e.b, e.l_new}) begin
      n_err++;
      $display("FAIL bounce_4cyc: got a=%h b=%h led=%b want a=%h b=%h led=%b",
               op_a, op_b, led, e.a, e.b, e.l_new);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   masks [4] = '{4'h4, 4'h9, 4'h8, 4'h8};
    logic [3:0]   sws   [4] = '{4'h0, 4'h9, 4'h0, 4'h0};
    logic [3:0]   want  [4] = '{4'h2, 4'hF, 4'h9, 4'hF};
    logic [W-1:0] a, b;
    logic [3:0]   l7, l8;
    exp_t         e;
    for (int i = 0; i < 4; i++) begin
      drive_press(masks[i], sws[i], a, b, l7, l8);
      e = sb_q.pop_front();
      n_vec++;
      if ({a, b, l7, l8} !== {e.a, e.b, e.l_old, e.l_new}) begin
        n_err++;
        $display("FAIL simul[%0d]: got a=%h b=%h led7=%h led8=%h want a=%h b=%h led7=%h led8=%h",
                 i, a, b, l7, l8, e.a, e.b, e.l_old, e.l_new);
      end
      n_vec++;
      if (l8 !== want[i]) begin n_err++; $display("FAIL simul_led[%0d]: got %h want %h", i, l8, want[i]); end
    end
    n_vec++; if (op_a !== 8'h9F) begin n_err++; $display("FAIL simul_op_a: got %h want 9f", op_a); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(posedge clk); #1;
    sw  = 4'h6;
    btn = 4'h2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_vec++; if (op_b !== '0) begin n_err++; $display("FAIL midreset_hold: got %h want 00", op_b); end
    reset = 1'b0;
    model_reset();
    model_apply(4'h2, 4'h6);
    e.a = m_a; e.b = m_b; e.l_old = 4'h0; e.l_new = model_led();
    sb_q.push_back(e);
    repeat (6) @(posedge clk);
    #1;
    n_vec++; if (op_b !== '0) begin n_err++; $display("FAIL midreset_early: got %h want 00", op_b); end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_vec++;
    if ({op_a, op_b} !== {e.a, e.b}) begin
      n_err++; $display("FAIL midreset_load: got a=%h b=%h want a=%h b=%h", op_a, op_b, e.a, e.b);
    end
    @(posedge clk); #1;
    n_vec++; if (led !== e.l_new) begin n_err++; $display("FAIL midreset_led: got %h want %h", led, e.l_new); end
    btn = 4'h0;
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (op_b !== 8'h06) begin n_err++; $display("FAIL midreset_single: got %h want 06", op_b); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_flags();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
